// File: rtl/byte_serial_adder_ctrl_pkg.sv
// Shared vector-lane definitions for the byte-serial add/sub sequencer:
// element-width encodings, controller state enum and the default operand width.
package byte_serial_adder_ctrl_pkg;

   localparam logic [1:0] SEW8  = 2'd0;
   localparam logic [1:0] SEW16 = 2'd1;
   localparam logic [1:0] SEW32 = 2'd2;
   localparam logic [1:0] SEW64 = 2'd3;

   localparam int MAX_BYTES_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Index of the most significant byte of an element: (1 << sew) - 1.
   function automatic logic [2:0] sew_last_idx(input logic [1:0] sew);
      return 3'((4'd1 << sew) - 4'd1);
   endfunction

endpackage

// File: rtl/byte_serial_adder_ctrl_if.sv
// Request/response bundle of the byte-serial adder; names are seen from the adder,
// so the requester (master) drives the *_i signals and the adder (slave) drives the *_o signals.
interface byte_serial_adder_ctrl_if
   import byte_serial_adder_ctrl_pkg::*;
#(
   parameter int MAX_BYTES = MAX_BYTES_DEF
);
   logic                     req_valid_i;
   logic                     req_ready_o;
   logic [8*MAX_BYTES-1:0]   op_a_i;
   logic [8*MAX_BYTES-1:0]   op_b_i;
   logic [1:0]               sew_i;
   logic                     sub_i;
   logic                     carry_i;
   logic                     resp_valid_o;
   logic                     resp_ready_i;
   logic [8*MAX_BYTES-1:0]   result_o;
   logic                     carry_o;

   modport master (
      output req_valid_i, op_a_i, op_b_i, sew_i, sub_i, carry_i, resp_ready_i,
      input  req_ready_o, resp_valid_o, result_o, carry_o
   );

   modport slave (
      input  req_valid_i, op_a_i, op_b_i, sew_i, sub_i, carry_i, resp_ready_i,
      output req_ready_o, resp_valid_o, result_o, carry_o
   );
endinterface

// File: rtl/byte_serial_adder_ctrl_kogge_stone_byte.sv
// 8-bit Kogge-Stone carry network: purely combinational, three prefix levels.
// o_carry[k] is the carry into bit k (o_carry[0] = i_cin), o_carry[8] is the byte carry-out.
module kogge_stone_byte (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  logic       i_cin,
   output logic [8:0] o_carry
);

   function automatic logic [15:0] ks_step(input logic [7:0] g, input logic [7:0] p, input int d);
      logic [7:0] g_n;
      logic [7:0] p_n;
      g_n = g;
      p_n = p;
      for (int i = 0; i < 8; i++) begin
         if (i >= d) begin
            g_n[i] = g[i] | (p[i] & g[i-d]);
            p_n[i] = p[i] & p[i-d];
         end
      end
      return {g_n, p_n};
   endfunction

   logic [7:0] w_g0, w_p0, w_g1, w_p1, w_g2, w_p2, w_g3, w_p3;

   assign w_g0 = i_a & i_b;
   assign w_p0 = i_a ^ i_b;
   assign {w_g1, w_p1} = ks_step(w_g0, w_p0, 1);
   assign {w_g2, w_p2} = ks_step(w_g1, w_p1, 2);
   assign {w_g3, w_p3} = ks_step(w_g2, w_p2, 4);

   // Group terms over [i:0] fold the byte carry-in in a single final level.
   assign o_carry[0]   = i_cin;
   assign o_carry[8:1] = w_g3 | (w_p3 & {8{i_cin}});

endmodule

// File: rtl/byte_serial_adder_ctrl.sv
// Byte-serial add/sub of 8..64-bit elements: one byte per cycle LSB first, response N+1 cycles after accept.
// Response held stable until resp_ready_i; a new request is taken in the DONE cycle; flush_i aborts everything.
module byte_serial_adder_ctrl
   import byte_serial_adder_ctrl_pkg::*;
#(
   parameter int MAX_BYTES = MAX_BYTES_DEF
)(
   input  logic                      clk_i,
   input  logic                      rsn_i,
   input  logic                      flush_i,
   byte_serial_adder_ctrl_if.slave   bus
);

   localparam int W  = 8 * MAX_BYTES;
   localparam int IW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

   state_t           r_state;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic [W-1:0]     r_result;
   logic [IW-1:0]    r_idx;
   logic [IW-1:0]    r_last;
   logic             r_sub;
   logic             r_carry;
   logic             r_carry_out;
   logic             r_resp_valid;

   logic             w_req_ready;
   logic             w_accept;
   logic [7:0]       w_a_byte;
   logic [7:0]       w_b_byte;
   logic [8:0]       w_carry_vec;
   logic [7:0]       w_sum;

   always_comb begin
      w_req_ready = 1'b0;
      case (r_state)
         IDLE:    w_req_ready = 1'b1;
         DONE:    w_req_ready = bus.resp_ready_i;
         default: w_req_ready = 1'b0;
      endcase
      if (flush_i) begin
         w_req_ready = 1'b0;
      end
   end

   assign w_accept = bus.req_valid_i & w_req_ready;

   assign w_a_byte = r_a[{r_idx, 3'b000} +: 8];
   assign w_b_byte = r_b[{r_idx, 3'b000} +: 8];

   kogge_stone_byte u_ks (
      .i_a     (w_a_byte),
      .i_b     (w_b_byte),
      .i_cin   (r_carry),
      .o_carry (w_carry_vec)
   );

   assign w_sum = w_a_byte ^ w_b_byte ^ w_carry_vec[7:0];

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         r_state      <= IDLE;
         r_a          <= '0;
         r_b          <= '0;
         r_result     <= '0;
         r_idx        <= '0;
         r_last       <= '0;
         r_sub        <= 1'b0;
         r_carry      <= 1'b0;
         r_carry_out  <= 1'b0;
         r_resp_valid <= 1'b0;
      end else if (flush_i) begin
         r_state      <= IDLE;
         r_result     <= '0;
         r_idx        <= '0;
         r_carry      <= 1'b0;
         r_carry_out  <= 1'b0;
         r_resp_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
            end
            BUSY: begin
               r_result[{r_idx, 3'b000} +: 8] <= w_sum;
               r_carry                        <= w_carry_vec[8];
               if (r_idx == r_last) begin
                  r_state      <= DONE;
                  r_resp_valid <= 1'b1;
                  // Subtraction runs as A + ~B + ~borrow, so the carry flips back into a borrow.
                  r_carry_out  <= w_carry_vec[8] ^ r_sub;
                  r_idx        <= '0;
               end else begin
                  r_idx <= r_idx + IW'(1);
               end
            end
            DONE: begin
               if (bus.resp_ready_i) begin
                  r_state      <= IDLE;
                  r_resp_valid <= 1'b0;
                  r_carry_out  <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase

         // Accept overrides the DONE->IDLE return, giving the back-to-back path.
         if (w_accept) begin
            r_state      <= BUSY;
            r_a          <= bus.op_a_i;
            r_b          <= bus.sub_i ? ~bus.op_b_i : bus.op_b_i;
            r_sub        <= bus.sub_i;
            r_carry      <= bus.carry_i ^ bus.sub_i;
            r_last       <= IW'(sew_last_idx(bus.sew_i));
            r_idx        <= '0;
            r_result     <= '0;
            r_resp_valid <= 1'b0;
            r_carry_out  <= 1'b0;
         end
      end
   end

   assign bus.req_ready_o  = w_req_ready;
   assign bus.resp_valid_o = r_resp_valid;
   assign bus.result_o     = r_result;
   assign bus.carry_o      = r_carry_out;

endmodule
